gearbox_scan_ctrl: RTL and testbench
====================================

Name: gearbox_scan_ctrl

Overview:
- Parametrised successor to the single-digit gearbox display controller.
- Runs entirely on the system clock, using internal clock enables in place of a divided clock.
- Gear count is configurable; adds reverse and neutral, input synchronisation and edge capture, and brake-driven stepped downshift.
- Drives a time-multiplexed 4-digit common-anode 7-segment display: gear character, brake indicator, last-shift direction.

Parameters:
- NUM_GEARS, 5, forward gears; legal range 1..9.
- TICK_DIV, 25_000_000, clk cycles per gear-update tick; must be ≥2.
- SCAN_DIV, 50_000, clk cycles per display digit slot; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- shift_up  in  1  raw asynchronous upshift button.
- shift_down  in  1  raw asynchronous downshift button.
- brake  in  1  raw asynchronous brake level.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low, exactly one low.
- gear  out  GW  encoded gear, GW = $clog2(NUM_GEARS+2); 0=R, 1=N, k+1=gear k.

Behaviour:
- Reset (async assert, sync release):
  - gear=1 (N); tick counter=0; scan counter=0; digit index=0.
  - pending flags clear; last-dir=none.
  - an=4'b1110; seg=pattern for 'N'.
- Input conditioning:
  - Each input passes through a 2-FF synchroniser.
  - Up/down rising edges (sync'd value 1, previous 0) set sticky pending flags pu/pd.
  - A raw rise becomes a pending flag 3 clk later.
  - Brake is used as a synchronised level (bs).
- Tick:
  - Counter 0..TICK_DIV-1; tick asserts for one cycle when count==TICK_DIV-1, then wraps to 0.
  - gear changes only on tick cycles.
- Gear update on tick, first matching rule wins:
  1. bs=1: if gear>2 then gear-1 and last-dir=down, else hold. Pending up is discarded; pending down is also discarded (brake subsumes it).
  2. pu&pd: both discarded, gear holds.
  3. pu: R→N, N→1, k→k+1; at NUM_GEARS hold (saturate). last-dir=up if changed.
  4. pd: k→k-1 for k≥2, 1→N, N→R; at R hold. last-dir=down if changed.
  - pu and pd clear on every tick, whether applied or discarded.
  - An edge detected in the same cycle as the tick is taken by the next tick, not lost.
- Display scan:
  - Scan counter 0..SCAN_DIV-1; on wrap, digit index increments mod 4.
  - an and seg are registered and change in the same cycle, one cycle after the index update.
  - an = ~(1<<index).
  - Digit 0: 'r' (gear=0), 'N' (gear=1), else decimal 1..9.
  - Digit 1: 'b' when bs=1, else blank.
  - Digit 2: 'U' / 'd' / blank for last-dir up/down/none.
  - Digit 3: blank.
  - Blank = 7'b1111111.
- Mid-operation reset forces all of the above reset values immediately; pending requests are lost.

Decomposition:
- gearbox_pkg:
  - Gear code constants: GEAR_R=0, GEAR_N=1.
  - Last-dir enum: NONE, UP, DOWN.
  - 7-seg pattern constants: digits 0-9, 'N', 'r', 'b', 'U', 'd', BLANK.
  - Function gear_to_seg.
- Sub-module seg7_scan4: owns the scan counter, digit index and registered an/seg; takes four 7-bit patterns.
- Synchronisers, edge detect, tick and gear FSM stay in the top.

Test Plan (NUM_GEARS=5, TICK_DIV=8, SCAN_DIV=2):
1. Reset pulse mid-run → gear=1, an=4'b1110, seg='N' in the same cycle as reset asserts.
2. Six shift_up pulses, one per tick → gear 2,3,4,5,6,6 (saturates at gear 5); digit 2 shows 'U'.
3. From N: shift_down, shift_down → gear 0 (R), held at 0; digit 0 shows 'r'; then one shift_up → gear=1.
4. From gear 5 (code 6), hold brake 5 ticks → codes 5,4,3,2,2; digit 1 shows 'b' while brake is high; a shift_up pulse during brake is dropped.
5. shift_up and shift_down both pulsed within one tick window → gear unchanged, both flags cleared at the tick.
6. Free-run 16 cycles → an sequence 1110,1101,1011,0111 repeating every 8 cycles; exactly one an bit low at all times.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared constants for the gearbox display controller: gear codes, shift
// direction, active-low 7-segment glyphs ({g,f,e,d,c,b,a}) and gear glyph lookup.
package gearbox_pkg;

   localparam int GEAR_R = 0;
   localparam int GEAR_N = 1;

   typedef enum logic [1:0] {NONE, UP, DOWN} dir_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_N     = 7'b1001000;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_U     = 7'b1000001;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Gear code to glyph: 0 -> 'r', 1 -> 'N', k+1 -> decimal k.
   function automatic logic [6:0] gear_to_seg(input logic [3:0] code);
      case (code)
         4'd0:    return SEG_R;
         4'd1:    return SEG_N;
         4'd2:    return SEG_1;
         4'd3:    return SEG_2;
         4'd4:    return SEG_3;
         4'd5:    return SEG_4;
         4'd6:    return SEG_5;
         4'd7:    return SEG_6;
         4'd8:    return SEG_7;
         4'd9:    return SEG_8;
         4'd10:   return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/gearbox_scan_ctrl_if.sv
// Button/brake inputs and display/gear outputs of the gearbox controller.
interface gearbox_scan_ctrl_if #(parameter int NUM_GEARS = 5);
   localparam int GW = $clog2(NUM_GEARS + 2);

   logic          shift_up;
   logic          shift_down;
   logic          brake;
   logic [6:0]    seg;
   logic [3:0]    an;
   logic [GW-1:0] gear;

   modport master (output shift_up, shift_down, brake, input seg, an, gear);
   modport slave  (input shift_up, shift_down, brake, output seg, an, gear);
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed 7-segment scanner with registered anode/segment drive.
module seg7_scan4
   import gearbox_pkg::*;
#(
   parameter int SCAN_DIV = 50_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0][6:0] pats,
   output logic [3:0]      an,
   output logic [6:0]      seg
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          wrap;

   assign wrap = (cnt == CW'(SCAN_DIV - 1));

   // Slot counter; digit index advances once per slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap) idx <= idx + 2'd1;
      end
   end

   // Anode and segment drive follow the index one cycle later, always together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= 4'b1110;
         seg <= SEG_N;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= pats[idx];
      end
   end
endmodule

// File: rtl/gearbox_scan_ctrl.sv
// Gearbox controller: synchronised buttons, tick-paced gear FSM with brake
// downshift, and a 4-digit scanned display (gear, brake, last shift direction).
module gearbox_scan_ctrl
   import gearbox_pkg::*;
#(
   parameter int NUM_GEARS = 5,
   parameter int TICK_DIV  = 25_000_000,
   parameter int SCAN_DIV  = 50_000
) (
   input logic               clk,
   input logic               reset,
   gearbox_scan_ctrl_if.slave io
);
   localparam int GW = $clog2(NUM_GEARS + 2);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [GW-1:0] GEAR_MAX = GW'(NUM_GEARS + 1);

   logic [2:0]      s1, s2;   // {brake, down, up}
   logic [1:0]      prev;
   logic            edge_up, edge_dn, bs;
   logic [TW-1:0]   tcnt;
   logic            tick;
   logic [GW-1:0]   gear;
   dir_e            last;
   logic            pu, pd;
   logic [3:0][6:0] pats;

   // Two-stage synchroniser plus previous-value register for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= {io.brake, io.shift_down, io.shift_up};
         s2   <= s1;
         prev <= s2[1:0];
      end
   end

   assign edge_up = s2[0] & ~prev[0];
   assign edge_dn = s2[1] & ~prev[1];
   assign bs      = s2[2];
   assign tick    = (tcnt == TW'(TICK_DIV - 1));

   // Gear-update tick counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tcnt <= '0;
      else       tcnt <= tick ? '0 : tcnt + 1'b1;
   end

   // Gear FSM: pending flags collect edges; a tick applies the first matching rule
   // and restarts the flags with any edge seen in that same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gear <= GW'(GEAR_N);
         last <= NONE;
         pu   <= 1'b0;
         pd   <= 1'b0;
      end else if (tick) begin
         pu <= edge_up;
         pd <= edge_dn;
         if (bs) begin
            if (gear > GW'(2)) begin
               gear <= gear - 1'b1;
               last <= DOWN;
            end
         end else if (pu && pd) begin
            gear <= gear;
         end else if (pu) begin
            if (gear != GEAR_MAX) begin
               gear <= gear + 1'b1;
               last <= UP;
            end
         end else if (pd) begin
            if (gear != GW'(GEAR_R)) begin
               gear <= gear - 1'b1;
               last <= DOWN;
            end
         end
      end else begin
         pu <= pu | edge_up;
         pd <= pd | edge_dn;
      end
   end

   // Glyphs for the four digit slots.
   always_comb begin
      pats[0] = gear_to_seg(4'(gear));
      pats[1] = bs ? SEG_B : SEG_BLANK;
      case (last)
         UP:      pats[2] = SEG_U;
         DOWN:    pats[2] = SEG_D;
         default: pats[2] = SEG_BLANK;
      endcase
      pats[3] = SEG_BLANK;
   end

   seg7_scan4 #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk   (clk),
      .reset (reset),
      .pats  (pats),
      .an    (io.an),
      .seg   (io.seg)
   );

   assign io.gear = gear;
endmodule

// File: tb/tb_gearbox_scan_ctrl.sv
// Directed bench for gearbox_scan_ctrl (NUM_GEARS=5, TICK_DIV=8, SCAN_DIV=2).
module tb_gearbox_scan_ctrl;
   import gearbox_pkg::*;

   localparam int TICK = 8;

   typedef struct {
      logic       up, dn, brk;
      logic [2:0] gear;
      logic       chk;
      logic [6:0] d0, d1, d2;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl [18];

   always #5 clk = ~clk;

   gearbox_scan_ctrl_if #(.NUM_GEARS(5)) bus ();

   gearbox_scan_ctrl #(.NUM_GEARS(5), .TICK_DIV(TICK), .SCAN_DIV(2)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   // Cycles since reset release; gear updates land on multiples of TICK.
   always @(posedge clk or posedge reset)
      if (reset) n <= 0;
      else       n <= n + 1;

   function automatic vec_t mk(input logic up, dn, brk, input logic [2:0] g,
                               input logic c, input logic [6:0] a, b, d);
      vec_t v;
      v.up = up; v.dn = dn; v.brk = brk; v.gear = g;
      v.chk = c; v.d0 = a; v.d1 = b; v.d2 = d;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      do @(negedge clk); while (n % TICK != 0);
   endtask

   task automatic pulse(input logic up, input logic dn);
      bus.shift_up   = up;
      bus.shift_down = dn;
      repeat (2) @(negedge clk);
      bus.shift_up   = 1'b0;
      bus.shift_down = 1'b0;
   endtask

   task automatic wait_digit(input int d, output logic ok);
      logic [3:0] exp_an;
      int k;
      exp_an = ~(4'b0001 << d);
      k = 0;
      while (bus.an !== exp_an && k < 20) begin
         @(negedge clk);
         k++;
      end
      ok = (bus.an === exp_an);
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL digit%0d_timeout: an=%b never reached %b", d, bus.an, exp_an);
      end
   endtask

   task automatic check_digits(input int i, input logic [6:0] d0, d1, d2);
      logic ok;
      wait_digit(0, ok); if (ok) check($sformatf("v%0d_digit0", i), 32'(bus.seg), 32'(d0));
      wait_digit(1, ok); if (ok) check($sformatf("v%0d_digit1", i), 32'(bus.seg), 32'(d1));
      wait_digit(2, ok); if (ok) check($sformatf("v%0d_digit2", i), 32'(bus.seg), 32'(d2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic ok;
      //              up dn brk gear chk d0         d1         d2
      tbl[0]  = mk(1, 0, 0, 3'd2, 0, '0, '0, '0);
      tbl[1]  = mk(1, 0, 0, 3'd3, 0, '0, '0, '0);
      tbl[2]  = mk(1, 0, 0, 3'd4, 0, '0, '0, '0);
      tbl[3]  = mk(1, 0, 0, 3'd5, 0, '0, '0, '0);
      tbl[4]  = mk(1, 0, 0, 3'd6, 0, '0, '0, '0);
      tbl[5]  = mk(1, 0, 0, 3'd6, 1, SEG_5, SEG_BLANK, SEG_U);
      tbl[6]  = mk(0, 0, 1, 3'd5, 0, '0, '0, '0);
      tbl[7]  = mk(0, 0, 1, 3'd4, 0, '0, '0, '0);
      tbl[8]  = mk(1, 0, 1, 3'd3, 0, '0, '0, '0);
      tbl[9]  = mk(0, 0, 1, 3'd2, 0, '0, '0, '0);
      tbl[10] = mk(0, 0, 1, 3'd2, 1, SEG_1, SEG_B, SEG_D);
      tbl[11] = mk(0, 0, 0, 3'd2, 1, SEG_1, SEG_BLANK, SEG_D);
      tbl[12] = mk(1, 1, 0, 3'd2, 0, '0, '0, '0);
      tbl[13] = mk(0, 0, 0, 3'd2, 0, '0, '0, '0);
      tbl[14] = mk(0, 1, 0, 3'd1, 0, '0, '0, '0);
      tbl[15] = mk(0, 1, 0, 3'd0, 1, SEG_R, SEG_BLANK, SEG_D);
      tbl[16] = mk(0, 1, 0, 3'd0, 0, '0, '0, '0);
      tbl[17] = mk(1, 0, 0, 3'd1, 1, SEG_N, SEG_BLANK, SEG_U);

      reset = 1'b1;
      bus.shift_up = 1'b0;
      bus.shift_down = 1'b0;
      bus.brake = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_gear", 32'(bus.gear), 32'd1);
      check("reset_an",   32'(bus.an),   32'b1110);
      check("reset_seg",  32'(bus.seg),  32'(SEG_N));
      reset = 1'b0;

      // One table entry per tick window: inputs applied right after a tick.
      for (int i = 0; i < 18; i++) begin
         bus.brake = tbl[i].brk;
         pulse(tbl[i].up, tbl[i].dn);
         wait_tick();
         check($sformatf("v%0d_gear", i), 32'(bus.gear), 32'(tbl[i].gear));
         if (tbl[i].chk) begin
            check_digits(i, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            wait_tick();
         end
      end

      // Free-running scan: align to the start of digit 0, then 16 cycles.
      wait_digit(3, ok);
      for (int k = 0; k < 4 && bus.an === 4'b0111; k++) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         logic [3:0] exp_an;
         exp_an = ~(4'b0001 << ((k / 2) % 4));
         check($sformatf("scan_an_c%0d", k), 32'(bus.an), 32'(exp_an));
         check($sformatf("scan_onehot_c%0d", k), $countones(~bus.an), 32'd1);
         @(negedge clk);
      end

      // Mid-run reset with a pending upshift: values forced at once, request lost.
      wait_tick();
      pulse(1'b1, 1'b0);
      wait_tick();
      check("pre_reset_gear", 32'(bus.gear), 32'd2);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_gear", 32'(bus.gear), 32'd1);
      check("midrst_an",   32'(bus.an),   32'b1110);
      check("midrst_seg",  32'(bus.seg),  32'(SEG_N));
      @(negedge clk);
      reset = 1'b0;
      repeat (2) wait_tick();
      check("post_rst_pending_lost", 32'(bus.gear), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
